seq_input_checker: RTL and testbench
====================================

// Module: seq_input_checker
// PURPOSE
//  Player-side counterpart of the sequence ROM: walks seq_addr from 0 to the current round's last index and
//  compares each player button press against the expected one-hot colour read back on seq_data.
//  Reports a one-cycle round_ok pulse on a full correct round and a one-cycle error pulse on a mismatch.
//  Sits between the button synchronisers and the game-control FSM. The ROM stays combinational.
// PARAMETERS
//  ADDR_W          4      sequence address width (max round length 2**ADDR_W)
//  COLOR_W         4      one-hot colour width (btn, seq_data, last_press)
//  TIMEOUT_CYCLES  50000  per-press timeout in clk cycles; used only with SEQ_TIMEOUT_EN
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  start       in   1        one-cycle pulse: begin checking a round (ignored while busy=1)
//  round_len   in   ADDR_W   index of last step in round (0 => one press); latched on accepted start
//  btn         in   COLOR_W  synchronised, debounced button levels, one bit per colour
//  seq_addr    out  ADDR_W   address to sequence ROM
//  seq_data    in   COLOR_W  expected one-hot colour for seq_addr (combinational, same cycle)
//  busy        out  1        1 while a round is being checked
//  press_valid out  1        one-cycle pulse: a correct press was accepted
//  last_press  out  COLOR_W  colour of the most recent detected press
//  round_ok    out  1        one-cycle pulse: all round_len+1 presses correct
//  error       out  1        one-cycle pulse: wrong colour, multi-button press or timeout
//  timeout     out  1        one-cycle pulse coincident with error when cause is timeout (0 if SEQ_TIMEOUT_EN off)
// BEHAVIOUR
//  - Reset: state=IDLE; seq_addr=0, busy=0, press_valid=0, last_press=0, round_ok=0, error=0, timeout=0,
//    len_q=0, btn_q=0. Reset mid-round aborts silently, no pulses.
//  - All outputs registered. btn_q = btn delayed one cycle. Press edge = (btn_q==0 && btn!=0).
//  - FSM: IDLE, WAIT_PRESS, WAIT_RELEASE, DONE, FAIL.
//    IDLE: start=1 -> len_q<=round_len, seq_addr<=0, busy<=1, go WAIT_PRESS.
//    WAIT_PRESS: on press edge, last_press<=btn.
//      btn is one-hot and btn==seq_data -> press_valid<=1, go WAIT_RELEASE.
//      Otherwise (mismatch or >1 bit set) -> go FAIL.
//      A button already held when WAIT_PRESS is entered is not a press; a release is needed first.
//    WAIT_RELEASE: wait for btn==0.
//      Then, if seq_addr==len_q -> go DONE.
//      Else seq_addr<=seq_addr+1 and go WAIT_PRESS.
//    DONE: round_ok<=1 for one cycle, busy<=0, go IDLE.
//    FAIL: error<=1 for one cycle, busy<=0, go IDLE.
//  - Latency: press edge in cycle k -> press_valid high in k+1. Release seen in cycle r -> round_ok or error high in r+2.
//  - seq_addr holds its value in IDLE, so the controller can read it back after a round.
//  - Wrap: len_q=2**ADDR_W-1 is legal. seq_addr never increments past len_q, so it never wraps.
//  - start while busy is ignored. round_len changes after start have no effect.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//    - Counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to WAIT_PRESS and counts while there.
//    - Reaching TIMEOUT_CYCLES with no press -> timeout<=1 and go FAIL, so error and timeout pulse together.
//    - WAIT_RELEASE is not timed.
//  SEQ_TIMEOUT_EN undefined: no counter; timeout tied 0; a player may wait indefinitely.
// STRUCTURE
//  - Shared package genius_pkg: colour constants COLOR_GREEN=4'b0001, COLOR_RED=4'b0010,
//    COLOR_YELLOW=4'b0100, COLOR_BLUE=4'b1000, plus the checker state encoding.
//    The ROM and the game controller use the same package.
//  - One sub-module: press_detect (btn register, edge pulse, one-hot check).
// TESTING (ROM contents at addr 0..3: 0001,0100,0001,1000)
//  1. start with round_len=2; press 0001, 0100, 0001 with releases between -> three press_valid pulses,
//     then round_ok, seq_addr=2, busy=0.
//  2. start with round_len=3; press 0001, then 0010 -> error pulse, last_press=0010, no round_ok, busy=0.
//  3. At step 0 press 0101 (two buttons) -> error; no press_valid.
//  4. btn=0001 already held at start -> no press; release then press 0001 -> press_valid.
//     Also: start pulsed again mid-round -> ignored.
//  5. rst_n low mid-round with seq_addr=1 -> all outputs 0 immediately; after release no pulses until next start.
//  6. SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=20: start, no press -> error=timeout=1 after 20 WAIT_PRESS cycles.
//     Without the macro, the same stimulus gives no error.

Source files
------------

// File: rtl/genius_pkg.sv
// Shared definitions for the colour-sequence game: colour codes, checker state encoding
// and a one-hot helper used by the press front end.
package genius_pkg;

    localparam logic [3:0] COLOR_GREEN  = 4'b0001;
    localparam logic [3:0] COLOR_RED    = 4'b0010;
    localparam logic [3:0] COLOR_YELLOW = 4'b0100;
    localparam logic [3:0] COLOR_BLUE   = 4'b1000;

    typedef enum logic [2:0] {
        CHK_IDLE         = 3'd0,
        CHK_WAIT_PRESS   = 3'd1,
        CHK_WAIT_RELEASE = 3'd2,
        CHK_DONE         = 3'd3,
        CHK_FAIL         = 3'd4
    } chk_state_e;

    // True when exactly one bit of v is set; callers zero-extend narrower vectors.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_input_checker_if.sv
// Bus between the sequence checker, the sequence ROM, the button front end and the game controller.
interface seq_input_checker_if #(
    parameter int ADDR_W  = 4,
    parameter int COLOR_W = 4
);
    logic               start;
    logic [ADDR_W-1:0]  round_len;
    logic [COLOR_W-1:0] btn;
    logic [ADDR_W-1:0]  seq_addr;
    logic [COLOR_W-1:0] seq_data;
    logic               busy;
    logic               press_valid;
    logic [COLOR_W-1:0] last_press;
    logic               round_ok;
    logic               error;
    logic               timeout;

    modport slave (
        input  start, round_len, btn, seq_data,
        output seq_addr, busy, press_valid, last_press, round_ok, error, timeout
    );

    modport master (
        output start, round_len, btn, seq_data,
        input  seq_addr, busy, press_valid, last_press, round_ok, error, timeout
    );
endinterface

// File: rtl/seq_input_checker_press_detect.sv
// Button front end: registers the synchronised levels and decodes press edge,
// one-hot validity and the all-released condition.
module press_detect
    import genius_pkg::*;
#(
    parameter int COLOR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COLOR_W-1:0] i_btn,
    output logic               o_press_edge,
    output logic               o_onehot,
    output logic               o_released
);

    localparam logic [COLOR_W-1:0] NONE = {COLOR_W{1'b0}};

    logic [COLOR_W-1:0] r_btn_q;

    // One-cycle delayed copy of the button levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q <= NONE;
        end else begin
            r_btn_q <= i_btn;
        end
    end

    // A press only counts when coming from all-released, so a held button never re-triggers
    always_comb begin
        o_press_edge = (r_btn_q == NONE) && (i_btn != NONE);
        o_onehot     = is_onehot(32'(i_btn));
        o_released   = (i_btn == NONE);
    end

endmodule

// File: rtl/seq_input_checker.sv
// Player-side sequence checker: steps seq_addr through a round and compares presses with the ROM.
// Optional per-press timeout is compiled in with `define SEQ_TIMEOUT_EN.
module seq_input_checker
    import genius_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int COLOR_W        = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_input_checker_if.slave bus
);

    localparam logic [ADDR_W-1:0]  ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
    localparam logic [COLOR_W-1:0] COLOR_NONE = {COLOR_W{1'b0}};

    chk_state_e         r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_seq_addr, w_seq_addr_nxt;
    logic [ADDR_W-1:0]  r_len_q, w_len_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_press_valid, w_press_valid_nxt;
    logic [COLOR_W-1:0] r_last_press, w_last_press_nxt;
    logic               r_round_ok, w_round_ok_nxt;
    logic               r_error, w_error_nxt;
    logic               w_press_edge;
    logic               w_onehot;
    logic               w_released;

`ifdef SEQ_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
    logic             r_tmo_hit, w_tmo_hit_nxt;
    logic             r_timeout, w_timeout_nxt;
`endif

    press_detect #(
        .COLOR_W (COLOR_W)
    ) u_press_detect (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_btn        (bus.btn),
        .o_press_edge (w_press_edge),
        .o_onehot     (w_onehot),
        .o_released   (w_released)
    );

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        w_state_nxt       = r_state;
        w_seq_addr_nxt    = r_seq_addr;
        w_len_nxt         = r_len_q;
        w_busy_nxt        = r_busy;
        w_press_valid_nxt = 1'b0;
        w_last_press_nxt  = r_last_press;
        w_round_ok_nxt    = 1'b0;
        w_error_nxt       = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        w_tmo_cnt_nxt     = r_tmo_cnt;
        w_tmo_hit_nxt     = r_tmo_hit;
        w_timeout_nxt     = 1'b0;
`endif
        case (r_state)
            CHK_IDLE: begin
                if (bus.start) begin
                    w_len_nxt      = bus.round_len;
                    w_seq_addr_nxt = ADDR_ZERO;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = CHK_WAIT_PRESS;
`ifdef SEQ_TIMEOUT_EN
                    w_tmo_cnt_nxt  = CNT_ZERO;
                    w_tmo_hit_nxt  = 1'b0;
`endif
                end else begin
                    w_state_nxt = CHK_IDLE;
                end
            end
            CHK_WAIT_PRESS: begin
                if (w_press_edge) begin
                    w_last_press_nxt = bus.btn;
                    if (w_onehot && (bus.btn == bus.seq_data)) begin
                        w_press_valid_nxt = 1'b1;
                        w_state_nxt       = CHK_WAIT_RELEASE;
                    end else begin
                        w_state_nxt = CHK_FAIL;
                    end
                end else begin
`ifdef SEQ_TIMEOUT_EN
                    if (r_tmo_cnt == TMO_LAST) begin
                        w_tmo_hit_nxt = 1'b1;
                        w_state_nxt   = CHK_FAIL;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + CNT_ONE;
                    end
`else
                    w_state_nxt = CHK_WAIT_PRESS;
`endif
                end
            end
            CHK_WAIT_RELEASE: begin
                if (w_released) begin
                    if (r_seq_addr == r_len_q) begin
                        w_state_nxt = CHK_DONE;
                    end else begin
                        w_seq_addr_nxt = r_seq_addr + ADDR_ONE;
                        w_state_nxt    = CHK_WAIT_PRESS;
`ifdef SEQ_TIMEOUT_EN
                        w_tmo_cnt_nxt  = CNT_ZERO;
`endif
                    end
                end else begin
                    w_state_nxt = CHK_WAIT_RELEASE;
                end
            end
            CHK_DONE: begin
                w_round_ok_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = CHK_IDLE;
            end
            CHK_FAIL: begin
                w_error_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = CHK_IDLE;
`ifdef SEQ_TIMEOUT_EN
                w_timeout_nxt = r_tmo_hit;
                w_tmo_hit_nxt = 1'b0;
`endif
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = CHK_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any round without pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= CHK_IDLE;
            r_seq_addr    <= ADDR_ZERO;
            r_len_q       <= ADDR_ZERO;
            r_busy        <= 1'b0;
            r_press_valid <= 1'b0;
            r_last_press  <= COLOR_NONE;
            r_round_ok    <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_seq_addr    <= w_seq_addr_nxt;
            r_len_q       <= w_len_nxt;
            r_busy        <= w_busy_nxt;
            r_press_valid <= w_press_valid_nxt;
            r_last_press  <= w_last_press_nxt;
            r_round_ok    <= w_round_ok_nxt;
            r_error       <= w_error_nxt;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Per-press timeout counter and the cause flag carried into FAIL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= CNT_ZERO;
            r_tmo_hit <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_tmo_hit <= w_tmo_hit_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.timeout = r_timeout;
`else
    // Without the counter the timeout pulse can never occur
    assign bus.timeout = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

    assign bus.seq_addr    = r_seq_addr;
    assign bus.busy        = r_busy;
    assign bus.press_valid = r_press_valid;
    assign bus.last_press  = r_last_press;
    assign bus.round_ok    = r_round_ok;
    assign bus.error       = r_error;

endmodule

// File: tb/tb_seq_input_checker.sv
// Self-checking bench for seq_input_checker: directed scenarios plus randomized rounds
// against a press-by-press model of the game rules.
module tb_seq_input_checker;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [3:0] rom [16];
    int         m_len;
    int         m_idx;
    bit         m_active;

    seq_input_checker_if #(.ADDR_W(4), .COLOR_W(4)) bus ();

    seq_input_checker #(
        .ADDR_W         (4),
        .COLOR_W        (4),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.seq_data = rom[bus.seq_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_pv"},  32'(bus.press_valid), 32'd0);
        chk({tag, "_ok"},  32'(bus.round_ok),    32'd0);
        chk({tag, "_err"}, 32'(bus.error),       32'd0);
        chk({tag, "_tmo"}, 32'(bus.timeout),     32'd0);
    endtask

    task automatic start_round(input int len);
        bus.start     = 1'b1;
        bus.round_len = 4'(len);
        step();
        bus.start     = 1'b0;
        bus.round_len = 4'($urandom_range(0, 15));
        m_len    = len;
        m_idx    = 0;
        m_active = 1'b1;
        chk("start_busy", 32'(bus.busy), 32'd1);
        chk("start_addr", 32'(bus.seq_addr), 32'd0);
    endtask

    // One press/release; expectation comes from the rules: exactly one colour and equal to rom[step]
    task automatic do_press(input logic [3:0] c);
        bit good;
        good = ($countones(c) == 1) && (c == rom[m_idx]);
        bus.btn = c;
        step();
        chk("press_valid", 32'(bus.press_valid), 32'(good));
        chk("last_press",  32'(bus.last_press),  32'(c));
        chk("no_early_err", 32'(bus.error), 32'd0);
        if (good) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                chk("pv_one_cycle", 32'(bus.press_valid), 32'd0);
                chk("hold_addr", 32'(bus.seq_addr), 32'(m_idx));
            end
            bus.btn = 4'b0000;
            step();
            chk("busy_release", 32'(bus.busy), 32'd1);
            chk("ok_not_early", 32'(bus.round_ok), 32'd0);
            if (m_idx == m_len) begin
                step();
                chk("round_ok",   32'(bus.round_ok), 32'd1);
                chk("busy_done",  32'(bus.busy),     32'd0);
                chk("addr_final", 32'(bus.seq_addr), 32'(m_len));
                chk("err_on_ok",  32'(bus.error),    32'd0);
                step();
                chk("ok_one_cycle", 32'(bus.round_ok), 32'd0);
                m_active = 1'b0;
            end else begin
                m_idx++;
                chk("addr_advance", 32'(bus.seq_addr), 32'(m_idx));
                repeat ($urandom_range(0, 2)) step();
            end
        end else begin
            step();
            chk("error",     32'(bus.error),    32'd1);
            chk("busy_fail", 32'(bus.busy),     32'd0);
            chk("no_ok",     32'(bus.round_ok), 32'd0);
            chk("tmo_cause", 32'(bus.timeout),  32'd0);
            bus.btn = 4'b0000;
            step();
            chk("err_one_cycle", 32'(bus.error), 32'd0);
            m_active = 1'b0;
        end
    endtask

    task automatic random_round(input int len);
        logic [3:0] c;
        start_round(len);
        while (m_active) begin
            if ($urandom_range(0, 9) < 8) c = rom[m_idx];
            else c = 4'($urandom_range(1, 15));
            do_press(c);
        end
    endtask

    initial begin
        logic [3:0] one;
        one = 4'b0001;
        for (int i = 0; i < 16; i++) rom[i] = one << $urandom_range(0, 3);
        rom[0] = 4'b0001;
        rom[1] = 4'b0100;
        rom[2] = 4'b0001;
        rom[3] = 4'b1000;

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.round_len = 4'd0;
        bus.btn       = 4'b0000;
        m_active      = 1'b0;
        repeat (3) step();
        chk("rst_addr", 32'(bus.seq_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_last", 32'(bus.last_press), 32'd0);
        chk_quiet("rst");
        rst_n = 1'b1;
        repeat (2) step();
        chk_quiet("idle");

        // Full correct round of three presses
        start_round(2);
        do_press(4'b0001);
        do_press(4'b0100);
        do_press(4'b0001);
        repeat (3) step();
        chk("addr_held_idle", 32'(bus.seq_addr), 32'd2);
        chk("busy_idle", 32'(bus.busy), 32'd0);

        // Wrong colour at step 1
        start_round(3);
        do_press(4'b0001);
        do_press(4'b0010);
        chk("last_after_err", 32'(bus.last_press), 32'h2);
        chk("busy_after_err", 32'(bus.busy), 32'd0);

        // Two buttons at once
        start_round(1);
        do_press(4'b0101);

        // Button held when the round begins, plus a start pulse mid-round
        bus.btn = 4'b0001;
        start_round(1);
        repeat (3) begin
            step();
            chk("held_no_press", 32'(bus.press_valid), 32'd0);
        end
        bus.start     = 1'b1;
        bus.round_len = 4'd0;
        step();
        bus.start = 1'b0;
        chk("restart_ignored_busy", 32'(bus.busy), 32'd1);
        chk("restart_ignored_addr", 32'(bus.seq_addr), 32'd0);
        bus.btn = 4'b0000;
        step();
        chk("release_no_press", 32'(bus.press_valid), 32'd0);
        do_press(4'b0001);
        do_press(4'b0100);

        // Reset in the middle of a round
        start_round(3);
        do_press(4'b0001);
        bus.btn = 4'b0100;
        @(posedge clk);
        #1;
        chk("pre_reset_pv", 32'(bus.press_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_addr", 32'(bus.seq_addr), 32'd0);
        chk("async_busy", 32'(bus.busy), 32'd0);
        chk("async_last", 32'(bus.last_press), 32'd0);
        chk_quiet("async");
        step();
        rst_n = 1'b1;
        step();
        bus.btn = 4'b0000;
        m_active = 1'b0;
        repeat (4) begin
            step();
            chk_quiet("post_reset");
            chk("post_reset_busy", 32'(bus.busy), 32'd0);
        end

        // Longest legal round: every address used once, no wrap
        start_round(15);
        while (m_active) do_press(rom[m_idx]);
        repeat (2) step();
        chk("wrap_addr_held", 32'(bus.seq_addr), 32'd15);

        // Player never presses
        start_round(0);
`ifdef SEQ_TIMEOUT_EN
        for (int i = 1; i <= 30; i++) begin
            step();
            chk("tmo_error", 32'(bus.error),   32'(i == 21));
            chk("tmo_pulse", 32'(bus.timeout), 32'(i == 21));
            chk("tmo_busy",  32'(bus.busy),    32'(i < 21));
        end
        m_active = 1'b0;
`else
        repeat (30) step();
        chk("no_tmo_error", 32'(bus.error), 32'd0);
        chk("no_tmo_pulse", 32'(bus.timeout), 32'd0);
        chk("no_tmo_busy", 32'(bus.busy), 32'd1);
        do_press(rom[0]);
`endif

        // Randomized rounds
        repeat (25) random_round($urandom_range(0, 6));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
